// File: rtl/giraffe_pkg.sv
// Shared FSM state encoding and sample-word tag constants for the ADC capture path.
package giraffe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic [1:0] TAG_MAIN = 2'b11;
   localparam logic [1:0] TAG_SUB  = 2'b00;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; q follows d two clk rising edges later.
module sync_2ff (
   input  logic clk,
   input  logic nrst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/adc_capture.sv
// Captures tagged ADC samples into a buffer on each ack rising edge; writes land 3 clk edges after ack rises.
// Registered read port for the UART sender; no backpressure, samples outside CAPTURE are dropped.
module adc_capture
   import giraffe_pkg::*;
#(
   parameter int N_bit  = 6,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 11
) (
   input  logic                clk_50M,
   input  logic                nrst,
   input  logic                start,
   input  logic                clear,
   input  logic                adc_ack,
   input  logic                adc_ack_sub,
   input  logic [N_bit-1:0]    dout_adc,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [N_bit+1:0]    rd_data,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W:0]     count,
   output logic                overflow
);

   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

   logic              ack_s2;
   logic              ack_sub_s2;
   logic [N_bit-1:0]  dout_s2;
   logic              ack_unit;
   logic              ack_hist;
   logic              ack_edge;
   logic [N_bit+1:0]  word;
   state_t            state;
   state_t            state_nxt;
   logic              wr_en;
   logic              ovf_set;
   logic [N_bit+1:0]  mem [DEPTH];

   sync_2ff u_sync_ack (
      .clk  (clk_50M),
      .nrst (nrst),
      .d    (adc_ack),
      .q    (ack_s2)
   );

   sync_2ff u_sync_ack_sub (
      .clk  (clk_50M),
      .nrst (nrst),
      .d    (adc_ack_sub),
      .q    (ack_sub_s2)
   );

   // Data shares the ack latency, so s2(dout) is valid whenever s2(ack) is high.
   for (genvar i = 0; i < N_bit; i++) begin : g_sync_dout
      sync_2ff u_sync_dout (
         .clk  (clk_50M),
         .nrst (nrst),
         .d    (dout_adc[i]),
         .q    (dout_s2[i])
      );
   end

   assign ack_unit = ack_s2 | ack_sub_s2;
   assign ack_edge = ack_unit & ~ack_hist;
   assign word     = {(ack_s2 ? TAG_MAIN : TAG_SUB), dout_s2};

   always_ff @(posedge clk_50M) begin
      if (!nrst) ack_hist <= 1'b0;
      else       ack_hist <= ack_unit;
   end

   always_ff @(posedge clk_50M) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      ovf_set   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!clear && start) state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (clear) begin
               state_nxt = ST_IDLE;
            end else if (ack_edge) begin
               wr_en = 1'b1;
               if (count == LAST) state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (clear)         state_nxt = ST_IDLE;
            else if (ack_edge) ovf_set   = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_CAPTURE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk_50M) begin
      if (!nrst)                                        count <= '0;
      else if (state == ST_IDLE && state_nxt == ST_CAPTURE) count <= '0;
      else if (wr_en)                                   count <= count + 1'b1;
   end

   always_ff @(posedge clk_50M) begin
      if (!nrst)        overflow <= 1'b0;
      else if (clear)   overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
   end

   // Buffer is not reset; nrst gates the write so a reset edge can never commit a sample.
   always_ff @(posedge clk_50M) begin
      if (wr_en && nrst) mem[count[ADDR_W-1:0]] <= word;
   end

   always_ff @(posedge clk_50M) begin
      if (!nrst) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture at DEPTH=4; inputs driven and outputs sampled on the falling edge.
module tb_adc_capture;

   logic       clk_50M = 1'b0;
   logic       nrst;
   logic       start;
   logic       clear;
   logic       adc_ack;
   logic       adc_ack_sub;
   logic [5:0] dout_adc;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic [2:0] count;
   logic       overflow;

   int nvec = 0;
   int nmis = 0;

   adc_capture #(
      .N_bit  (6),
      .DEPTH  (4),
      .ADDR_W (2)
   ) dut (
      .clk_50M     (clk_50M),
      .nrst        (nrst),
      .start       (start),
      .clear       (clear),
      .adc_ack     (adc_ack),
      .adc_ack_sub (adc_ack_sub),
      .dout_adc    (dout_adc),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .count       (count),
      .overflow    (overflow)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic pulse_ack(input logic main, input logic sub, input logic [5:0] d);
      dout_adc    = d;
      adc_ack     = main;
      adc_ack_sub = sub;
      step(4);
      adc_ack     = 1'b0;
      adc_ack_sub = 1'b0;
      step(3);
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      rd_addr = a;
      step(1);
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      step(1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      nrst = 1'b1;
   endtask

   initial begin
      nrst        = 1'b0;
      start       = 1'b0;
      clear       = 1'b0;
      adc_ack     = 1'b0;
      adc_ack_sub = 1'b0;
      dout_adc    = '0;
      rd_addr     = '0;
      step(2);
      do_reset();
      step(1);

      // Full run of four main-ADC samples.
      pulse_start();
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_count", 32'(count), 32'd0);
      pulse_ack(1'b1, 1'b0, 6'd5);
      pulse_ack(1'b1, 1'b0, 6'd6);
      pulse_ack(1'b1, 1'b0, 6'd7);
      pulse_ack(1'b1, 1'b0, 6'd8);
      chk("run_done", 32'(done), 32'd1);
      chk("run_busy", 32'(busy), 32'd0);
      chk("run_count", 32'(count), 32'd4);
      read_chk("mem0", 2'd0, 8'hC5);
      rd_addr = 2'd1;
      chk("rd_lag", 32'(rd_data), 32'hC5);
      step(1);
      chk("mem1", 32'(rd_data), 32'hC6);
      read_chk("mem2", 2'd2, 8'hC7);
      read_chk("mem3", 2'd3, 8'hC8);

      // Ack in DONE flags overflow and leaves the buffer alone.
      pulse_ack(1'b1, 1'b0, 6'd9);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      chk("ovf_done", 32'(done), 32'd1);
      read_chk("ovf_mem0", 2'd0, 8'hC5);
      read_chk("ovf_mem3", 2'd3, 8'hC8);
      pulse_clear();
      chk("clr_done", 32'(done), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_count_hold", 32'(count), 32'd4);

      // Acks in IDLE are dropped.
      do_reset();
      pulse_ack(1'b1, 1'b0, 6'd1);
      pulse_ack(1'b0, 1'b1, 6'd2);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_ovf", 32'(overflow), 32'd0);

      // Sub-ADC sample: write lands on the third rising edge after ack rises.
      pulse_start();
      dout_adc    = 6'h2A;
      adc_ack_sub = 1'b1;
      step(2);
      chk("lat_edge2", 32'(count), 32'd0);
      step(1);
      chk("lat_edge3", 32'(count), 32'd1);
      step(1);
      adc_ack_sub = 1'b0;
      step(3);
      read_chk("sub_mem0", 2'd0, 8'h2A);

      // Ack held for 100 cycles produces one write.
      dout_adc = 6'd3;
      adc_ack  = 1'b1;
      step(100);
      adc_ack  = 1'b0;
      step(3);
      chk("hold_count", 32'(count), 32'd2);
      read_chk("hold_mem1", 2'd1, 8'hC3);
      pulse_start();
      chk("start_ign_count", 32'(count), 32'd2);

      // Mid-run reset aborts capture but keeps the buffer.
      do_reset();
      pulse_ack(1'b1, 1'b0, 6'd4);
      chk("post_rst_count", 32'(count), 32'd0);
      read_chk("post_rst_mem0", 2'd0, 8'h2A);
      read_chk("post_rst_mem1", 2'd1, 8'hC3);

      // Clear beats start; clear in CAPTURE keeps count.
      clear = 1'b1;
      start = 1'b1;
      step(1);
      clear = 1'b0;
      start = 1'b0;
      chk("cs_idle_busy", 32'(busy), 32'd0);
      pulse_start();
      pulse_ack(1'b0, 1'b1, 6'h11);
      chk("cap_count", 32'(count), 32'd1);
      clear = 1'b1;
      start = 1'b1;
      step(1);
      clear = 1'b0;
      start = 1'b0;
      chk("cs_cap_busy", 32'(busy), 32'd0);
      chk("cs_cap_count", 32'(count), 32'd1);
      read_chk("cap_mem0", 2'd0, 8'h11);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
